// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage feeding the instruction register.
//
// Owns the PC. Issues word fetches over a req/gnt + in-order rvalid
// interface. Buffers returned words with their PCs in a DEPTH-entry
// in-order prefetch FIFO. Branch/jump redirects flush the FIFO. Responses
// still in flight at a redirect are counted in r_discard and dropped when
// they return.
//
// Parameters:
//   DEPTH     prefetch FIFO entries (power of 2, >= 2). This is also the cap
//             on fetches outstanding plus buffered.
//   RESET_PC  PC loaded on reset.
//
// Ports:
//   CLK, RESET                      clock; synchronous active-low reset
//   imem_req/imem_addr/imem_gnt     fetch request channel (word aligned)
//   imem_rvalid/imem_rdata          in-order read response
//   redirect/redirect_pc            taken branch/jump, restart fetch
//   ins_valid/ins_data/ins_pc       FIFO head towards instruction register
//   ins_ready                       instruction register consumes head
//
// Optional macro FETCH_PERF_EN adds saturating 32-bit counters:
//   perf_fetched (pops), perf_flushed (entries cleared + responses dropped),
//   perf_starve (cycles out of reset with ins_ready && !ins_valid).

module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    output logic [31:0] ins_data,
    output logic [31:0] ins_pc,
    input  logic        ins_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
    output logic [31:0] perf_starve
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW:0]   CREDIT = (CW+1)'(DEPTH);

    logic [31:0]   r_fetch_pc, r_resp_pc;
    logic [CW-1:0] r_outstanding, r_discard, r_count;
    logic [AW-1:0] r_wptr, r_rptr;
    logic [31:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];

    logic [CW:0]   w_inuse;
    logic          w_grant, w_push, w_drop, w_pop;
    logic [CW-1:0] w_out_next;
    logic [31:0]   w_redir_pc;

    // Credit covers both in-flight and buffered words, so every response
    // always has a FIFO slot waiting for it.
    assign w_inuse    = {1'b0, r_outstanding} + {1'b0, r_count};
    assign imem_req   = RESET && !redirect && (w_inuse < CREDIT);
    assign imem_addr  = r_fetch_pc;
    assign w_grant    = imem_req && imem_gnt;
    assign w_drop     = imem_rvalid && (r_discard != '0);
    assign w_push     = imem_rvalid && !redirect && (r_discard == '0);
    assign w_pop      = ins_valid && ins_ready && !redirect;
    assign w_out_next = r_outstanding + CW'(w_grant) - CW'(imem_rvalid);
    assign w_redir_pc = {redirect_pc[31:2], 2'b00};

    assign ins_valid = (r_count != '0);
    assign ins_data  = r_fifo_data[r_rptr];
    assign ins_pc    = r_fifo_pc[r_rptr];

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect) begin
                // Everything still in flight after this cycle is stale.
                // Any response this cycle is dropped because no push happens.
                r_fetch_pc <= w_redir_pc;
                r_resp_pc  <= w_redir_pc;
                r_discard  <= w_out_next;
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end else begin
                if (w_grant)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_drop)
                    r_discard <= r_discard - 1'b1;
                if (w_push) begin
                    r_fifo_pc[r_wptr]   <= r_resp_pc;
                    r_fifo_data[r_wptr] <= imem_rdata;
                    r_wptr              <= r_wptr + 1'b1;
                    r_resp_pc           <= r_resp_pc + 32'd4;
                end
                if (w_pop)
                    r_rptr <= r_rptr + 1'b1;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
            assert (!(w_push && !w_pop && r_count == FULL))
                else $error("fetch_unit: push into full prefetch FIFO");
        end
    end

`ifdef FETCH_PERF_EN
    logic [CW:0]  w_flush_inc;
    logic [32:0]  w_fetched_sum, w_flushed_sum, w_starve_sum;

    assign w_flush_inc   = redirect ? ({1'b0, r_count} + (CW+1)'(imem_rvalid))
                                    : (CW+1)'(w_drop);
    assign w_fetched_sum = {1'b0, perf_fetched} + 33'(w_pop);
    assign w_flushed_sum = {1'b0, perf_flushed} + 33'(w_flush_inc);
    assign w_starve_sum  = {1'b0, perf_starve}  + 33'(!ins_valid && ins_ready);

    // A carry out of bit 31 means the counter would wrap, so it holds at all-ones.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
            perf_starve  <= '0;
        end else begin
            perf_fetched <= w_fetched_sum[32] ? 32'hFFFF_FFFF : w_fetched_sum[31:0];
            perf_flushed <= w_flushed_sum[32] ? 32'hFFFF_FFFF : w_flushed_sum[31:0];
            perf_starve  <= w_starve_sum[32]  ? 32'hFFFF_FFFF : w_starve_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. A memory model with per-request latency answers in
// order. The reference model tracks an epoch per request (bumped on each
// redirect or reset), the expected instruction stream (the target PC,
// then +4 per delivered word) and the count of words the fetch unit should
// be holding.
module tb_fetch_unit;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        CLK, RESET;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect, ins_valid, ins_ready;
    logic [31:0] redirect_pc, ins_data, ins_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed, perf_starve;
`endif

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .CLK(CLK), .RESET(RESET),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .ins_valid(ins_valid), .ins_data(ins_data), .ins_pc(ins_pc),
        .ins_ready(ins_ready)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed),
        .perf_starve(perf_starve)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    req_t        mq[$];
    int          cyc, epoch, buffered, last_due, lat_lo, lat_hi;
    logic [31:0] m_fetch, m_exp, last_pop_pc;
    bit          mdl_ok;
    int          n_checks, n_pass, grants_seen, pops_seen;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_5A3C;
    endfunction

    // One clock cycle: present the memory response, compare the DUT with
    // the model at the negedge, then advance the model at the posedge.
    task automatic tick();
        bit          exp_req, grant, pop, resp;
        req_t        h;
        int          due;
        logic [31:0] pc_s;
        resp = RESET && (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rvalid = resp;
        imem_rdata  = resp ? mem_word(mq[0].addr) : $urandom;
        @(negedge CLK);
        exp_req = RESET && !redirect && (mq.size() + buffered < DEPTH);
        pop = 0;
        pc_s = ins_pc;
        if (mdl_ok) begin
            n_checks++;
            if (imem_req !== exp_req) $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req);
            else n_pass++;
            if (exp_req) begin
                n_checks++;
                if (imem_addr !== m_fetch) $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_fetch);
                else n_pass++;
            end
            if (RESET && !redirect) begin
                n_checks++;
                if (ins_valid !== (buffered > 0)) $display("FAIL ins_valid cyc=%0d got=%b exp=%b", cyc, ins_valid, buffered > 0);
                else n_pass++;
                if (buffered > 0 && ins_ready) begin
                    pop = 1;
                    n_checks++;
                    if (ins_pc !== m_exp || ins_data !== mem_word(m_exp))
                        $display("FAIL stream cyc=%0d got pc=%h data=%h exp pc=%h data=%h", cyc, ins_pc, ins_data, m_exp, mem_word(m_exp));
                    else n_pass++;
                end
            end
        end
        grant = mdl_ok && exp_req && imem_gnt;
        @(posedge CLK);
        if (!RESET) begin
            mq.delete();
            buffered = 0; epoch++; mdl_ok = 1;
            m_fetch = RST_PC; m_exp = RST_PC; last_due = cyc;
        end else if (redirect) begin
            if (resp) void'(mq.pop_front());
            epoch++; buffered = 0;
            m_fetch = redirect_pc & ~32'h3; m_exp = m_fetch;
        end else begin
            if (resp) begin
                h = mq.pop_front();
                if (h.epoch == epoch) buffered++;
            end
            if (pop) begin
                buffered--; m_exp += 4; pops_seen++; last_pop_pc = pc_s;
            end
            if (grant) begin
                due = cyc + $urandom_range(lat_hi, lat_lo);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq.push_back('{addr: m_fetch, epoch: epoch, due: due});
                m_fetch += 4; grants_seen++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0; redirect = 1'b0;
        tick();
        RESET = 1'b1;
    endtask

    task automatic next_pop(output logic [31:0] pc, output bit ok);
        int p;
        p = pops_seen; ok = 0; pc = 'x;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (pops_seen != p) begin ok = 1; pc = last_pop_pc; end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b1; ins_ready = 1'b1; lat_lo = 1; lat_hi = 1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", imem_req); else n_pass++;
        tick(); tick();
        RESET = 1'b1; #1;
        n_checks++;
        if (ins_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", ins_valid); else n_pass++;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC)
            $display("FAIL reset_fetch got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, RST_PC);
        else n_pass++;
    endtask

    task automatic test_stream();
        int gaps, p;
        lat_lo = 1; lat_hi = 1; imem_gnt = 1; ins_ready = 1;
        do_reset();
        gaps = 0; p = pops_seen;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i >= 2 && ins_valid !== 1'b1) gaps++;
        end
        n_checks++;
        if (gaps !== 0) $display("FAIL stream_gaps got=%0d exp=0", gaps); else n_pass++;
        n_checks++;
        if (pops_seen - p !== 28) $display("FAIL stream_rate got=%0d exp=28", pops_seen - p); else n_pass++;
    endtask

    task automatic test_backpressure();
        int g;
        lat_lo = 1; lat_hi = 1; imem_gnt = 1; ins_ready = 0;
        do_reset();
        g = grants_seen;
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (grants_seen - g !== DEPTH) $display("FAIL bp_grants got=%0d exp=%0d", grants_seen - g, DEPTH); else n_pass++;
        n_checks++;
        if (imem_req !== 1'b0 || ins_valid !== 1'b1 || ins_pc !== 32'h0)
            $display("FAIL bp_hold got req=%b valid=%b pc=%h exp req=0 valid=1 pc=0", imem_req, ins_valid, ins_pc);
        else n_pass++;
        ins_ready = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (last_pop_pc !== 32'(4 * i)) $display("FAIL bp_resume got=%h exp=%h", last_pop_pc, 32'(4 * i));
            else n_pass++;
        end
    endtask

    task automatic test_redirect_stale();
        logic [31:0] pc;
        bit ok;
        lat_lo = 3; lat_hi = 3; imem_gnt = 1; ins_ready = 1;
        do_reset();
        for (int i = 0; i < 10 && mq.size() < 2; i++) tick();
        redirect = 1; redirect_pc = 32'h40;
        tick();
        redirect = 0;
        next_pop(pc, ok);
        n_checks++;
        if (!ok || pc !== 32'h40) $display("FAIL stale_first got=%h ok=%0d exp=40", pc, ok); else n_pass++;
        next_pop(pc, ok);
        n_checks++;
        if (!ok || pc !== 32'h44) $display("FAIL stale_second got=%h ok=%0d exp=44", pc, ok); else n_pass++;
    endtask

    task automatic test_unaligned();
        logic [31:0] pc;
        bit ok;
        lat_lo = 1; lat_hi = 1; imem_gnt = 1; ins_ready = 1;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        redirect = 1; redirect_pc = 32'h103;
        tick();
        redirect = 0; #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100)
            $display("FAIL unaligned_addr got req=%b addr=%h exp req=1 addr=100", imem_req, imem_addr);
        else n_pass++;
        next_pop(pc, ok);
        n_checks++;
        if (!ok || pc !== 32'h100) $display("FAIL unaligned_pc got=%h ok=%0d exp=100", pc, ok); else n_pass++;
    endtask

    task automatic test_double_redirect();
        logic [31:0] pc;
        bit ok;
        lat_lo = 3; lat_hi = 3; imem_gnt = 1; ins_ready = 1;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        redirect = 1; redirect_pc = 32'h80; tick();
        redirect_pc = 32'hC0; tick();
        redirect = 0;
        next_pop(pc, ok);
        n_checks++;
        if (!ok || pc !== 32'hC0) $display("FAIL dbl_first got=%h ok=%0d exp=C0", pc, ok); else n_pass++;
        next_pop(pc, ok);
        n_checks++;
        if (!ok || pc !== 32'hC4) $display("FAIL dbl_second got=%h ok=%0d exp=C4", pc, ok); else n_pass++;
        ins_ready = 0;
        for (int i = 0; i < 30; i++) tick();
        n_checks++;
        if (imem_req !== 1'b0 || ins_valid !== 1'b1)
            $display("FAIL dbl_settle got req=%b valid=%b exp req=0 valid=1", imem_req, ins_valid);
        else n_pass++;
        ins_ready = 1;
    endtask

    task automatic test_reset_midstream();
        logic [31:0] pc;
        bit ok;
        lat_lo = 1; lat_hi = 1; imem_gnt = 1; ins_ready = 0;
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        do_reset(); #1;
        n_checks++;
        if (ins_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC)
            $display("FAIL mid_reset_full got valid=%b req=%b addr=%h exp valid=0 req=1 addr=%h", ins_valid, imem_req, imem_addr, RST_PC);
        else n_pass++;
        lat_lo = 3; lat_hi = 3; ins_ready = 1;
        for (int i = 0; i < 12; i++) tick();
        do_reset();
        next_pop(pc, ok);
        n_checks++;
        if (!ok || pc !== RST_PC) $display("FAIL mid_reset_inflight got=%h ok=%0d exp=%h", pc, ok, RST_PC); else n_pass++;
    endtask

    task automatic test_random();
        int p;
        lat_lo = 1; lat_hi = 4;
        do_reset();
        p = pops_seen;
        for (int i = 0; i < 3000; i++) begin
            imem_gnt    = ($urandom_range(3, 0) != 0);
            ins_ready   = ($urandom_range(3, 0) != 0);
            redirect    = ($urandom_range(99, 0) < 3);
            redirect_pc = $urandom;
            RESET       = ($urandom_range(999, 0) >= 3);
            tick();
        end
        redirect = 0; RESET = 1;
        n_checks++;
        if (pops_seen - p < 200) $display("FAIL random_progress got=%0d exp>=200", pops_seen - p); else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; epoch = 0; buffered = 0; last_due = 0;
        grants_seen = 0; pops_seen = 0; mdl_ok = 0; last_pop_pc = '0;
        m_fetch = RST_PC; m_exp = RST_PC;
        RESET = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        redirect = 0; redirect_pc = '0; ins_ready = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stale();
        test_unaligned();
        test_double_redirect();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
